// File: rtl/router_pkg.sv
// Shared types and constants for the router ingress path.
package router_pkg;
  localparam int         NUM_PORTS    = 3;
  localparam logic [1:0] ADDR_INVALID = 2'd3;
  localparam logic [5:0] MAX_PAYLOAD  = 6'd63;

  // Header byte layout: [7:2] payload length, [1:0] destination
  typedef struct packed {
    logic [5:0] len;
    logic [1:0] addr;
  } hdr_t;

  typedef enum logic [2:0] {
    DECODE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, CHECK_PARITY, DROP
  } state_e;

  // Per-port status lookup; the invalid address never selects a FIFO
  function automatic logic port_sel(input logic [NUM_PORTS-1:0] v, input logic [1:0] a);
    case (a)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] a);
    case (a)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction
endpackage

// File: rtl/router_parity.sv
// Running XOR of packet bytes; clear wins over enable.
module router_parity (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] parity
);
  logic [7:0] par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (clear)   par_d = 8'h00;
    else if (en) par_d = par_q ^ din;
  end

  always_ff @(posedge clk) begin
    if (reset) par_q <= 8'h00;
    else       par_q <= par_d;
  end

  assign parity = par_q;
endmodule

// File: rtl/router_ingress.sv
// Router ingress: decodes header, streams packet into the selected output FIFO, checks parity.
// Optional length check enabled by defining ROUTER_INGRESS_LEN_CHECK_EN.
module router_ingress
  import router_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           data_in,
  input  logic                 pkt_valid,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  output logic [7:0]           dout,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 lfd_state,
  output logic                 busy,
  output logic                 parity_done,
  output logic                 err,
  output logic                 len_err
);
  state_e               state_q, state_d;
  hdr_t                 hdr_q, hdr_d;
  logic [1:0]           addr_q, addr_d;
  logic [7:0]           rx_parity_q, rx_parity_d;
  logic [7:0]           dout_q, dout_d;
  logic [NUM_PORTS-1:0] we_q, we_d;
  logic                 lfd_q, lfd_d, pdone_q, pdone_d, err_q, err_d;
  logic                 par_clr, par_en;
  logic [7:0]           par_din, par_out;
  logic                 wr, wr_lfd;
  logic [7:0]           wr_byte;
  logic                 sel_full, sel_empty, sel_srst;

  assign sel_full  = port_sel(fifo_full,  addr_q);
  assign sel_empty = port_sel(fifo_empty, addr_q);
  assign sel_srst  = port_sel(soft_reset, addr_q);

  always_comb begin
    case (state_q)
      WAIT_EMPTY, LOAD_FIRST, CHECK_PARITY: busy = 1'b1;
      LOAD_DATA:                            busy = sel_full;
      default:                              busy = 1'b0;
    endcase
  end

`ifdef ROUTER_INGRESS_LEN_CHECK_EN
  logic [5:0] cnt_q, cnt_d;
  logic       len_err_q, len_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    addr_d      = addr_q;
    rx_parity_d = rx_parity_q;
    err_d       = err_q;
    pdone_d     = 1'b0;
    wr          = 1'b0;
    wr_lfd      = 1'b0;
    wr_byte     = data_in;
    par_clr     = 1'b0;
    par_en      = 1'b0;
    par_din     = data_in;
`ifdef ROUTER_INGRESS_LEN_CHECK_EN
    cnt_d       = cnt_q;
    len_err_d   = len_err_q;
`endif
    case (state_q)
      DECODE: if (pkt_valid) begin
        hdr_d   = data_in;
        addr_d  = data_in[1:0];
        par_clr = 1'b1;
        err_d   = 1'b0;
`ifdef ROUTER_INGRESS_LEN_CHECK_EN
        cnt_d     = 6'd0;
        len_err_d = 1'b0;
`endif
        if (data_in[1:0] == ADDR_INVALID)           state_d = DROP;
        else if (port_sel(fifo_empty, data_in[1:0])) state_d = LOAD_FIRST;
        else                                         state_d = WAIT_EMPTY;
      end
      WAIT_EMPTY: begin
        if (sel_srst)       state_d = pkt_valid ? DROP : DECODE;
        else if (sel_empty) state_d = LOAD_FIRST;
      end
      LOAD_FIRST: begin
        if (sel_srst) state_d = pkt_valid ? DROP : DECODE;
        else begin
          wr      = 1'b1;
          wr_lfd  = 1'b1;
          wr_byte = hdr_q;
          par_en  = 1'b1;
          par_din = hdr_q;
          state_d = LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        if (sel_srst) state_d = pkt_valid ? DROP : DECODE;
        else if (!sel_full) begin
          wr = 1'b1;
          if (pkt_valid) begin
            par_en = 1'b1;
`ifdef ROUTER_INGRESS_LEN_CHECK_EN
            if (cnt_q != MAX_PAYLOAD) cnt_d = cnt_q + 6'd1;
`endif
          end else begin
            // pkt_valid low marks the trailing parity byte
            rx_parity_d = data_in;
            state_d     = CHECK_PARITY;
          end
        end
      end
      CHECK_PARITY: begin
        err_d   = (rx_parity_q != par_out);
        pdone_d = 1'b1;
`ifdef ROUTER_INGRESS_LEN_CHECK_EN
        len_err_d = (cnt_q != hdr_q.len);
`endif
        state_d = DECODE;
      end
      DROP:    if (!pkt_valid) state_d = DECODE;
      default: state_d = DECODE;
    endcase
    we_d   = wr ? port_onehot(addr_q) : '0;
    dout_d = wr ? wr_byte : dout_q;
    lfd_d  = wr & wr_lfd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DECODE;
      hdr_q       <= '0;
      addr_q      <= 2'd0;
      rx_parity_q <= 8'h00;
      dout_q      <= 8'h00;
      we_q        <= '0;
      lfd_q       <= 1'b0;
      pdone_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      addr_q      <= addr_d;
      rx_parity_q <= rx_parity_d;
      dout_q      <= dout_d;
      we_q        <= we_d;
      lfd_q       <= lfd_d;
      pdone_q     <= pdone_d;
      err_q       <= err_d;
    end
  end

`ifdef ROUTER_INGRESS_LEN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 6'd0;
      len_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end
  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

  router_parity u_parity (
    .clk    (clk),
    .reset  (reset),
    .clear  (par_clr),
    .en     (par_en),
    .din    (par_din),
    .parity (par_out)
  );

  assign dout        = dout_q;
  assign write_enb   = we_q;
  assign lfd_state   = lfd_q;
  assign parity_done = pdone_q;
  assign err         = err_q;
endmodule

// File: tb/tb_router_ingress.sv
// Directed bench for router_ingress: FIFO writes captured on negedge and compared per packet.
module tb_router_ingress;
  logic       clk = 1'b0;
  logic       reset, pkt_valid, lfd_state, busy, parity_done, err, len_err;
  logic [7:0] data_in, dout;
  logic [2:0] fifo_full, fifo_empty, soft_reset, write_enb;

  int vecs = 0, fails = 0, pd_cnt = 0, pd0 = 0, got_base = 0;
  logic [11:0] got_q[$];
  logic [11:0] exp_q[$];

`ifdef ROUTER_INGRESS_LEN_CHECK_EN
  localparam logic LEN_EXP = 1'b1;
`else
  localparam logic LEN_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  router_ingress dut (
    .clk(clk), .reset(reset), .data_in(data_in), .pkt_valid(pkt_valid),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .dout(dout), .write_enb(write_enb), .lfd_state(lfd_state), .busy(busy),
    .parity_done(parity_done), .err(err), .len_err(len_err)
  );

  always @(negedge clk) begin
    if (write_enb !== 3'b000) got_q.push_back({write_enb, lfd_state, dout});
    if (parity_done === 1'b1) pd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    data_in = 8'h00; pkt_valid = 1'b0;
    repeat (n) cyc();
  endtask

  // Present a byte and hold it until the DUT takes it (busy low at the edge)
  task automatic send(input logic [7:0] d, input logic v);
    bit done = 1'b0;
    data_in = d; pkt_valid = v;
    for (int k = 0; k < 40 && !done; k++) begin
      #1 done = (busy === 1'b0);
      cyc();
    end
    chk("send_accept", 32'(done), 32'd1);
  endtask

  task automatic ex(input logic [2:0] we, input logic lfd, input logic [7:0] d);
    exp_q.push_back({we, lfd, d});
  endtask

  task automatic cmp(input string tag);
    chk({tag, "_count"}, 32'(got_q.size() - got_base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (got_base + i < got_q.size()) chk(tag, 32'(got_q[got_base + i]), 32'(exp_q[i]));
    got_base = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; data_in = 8'h00; pkt_valid = 1'b0;
    fifo_full = 3'b000; fifo_empty = 3'b111; soft_reset = 3'b000;
    repeat (2) cyc();
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_we", 32'(write_enb), 32'h0);
    chk("rst_lfd", 32'(lfd_state), 32'h0);
    chk("rst_pdone", 32'(parity_done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_lenerr", 32'(len_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    cyc();

    // good packet to FIFO1
    send(8'h0D, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
    pd0 = pd_cnt;
    send(8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33, 0);
    idle(3);
    ex(3'b010, 1, 8'h0D); ex(3'b010, 0, 8'h11); ex(3'b010, 0, 8'h22);
    ex(3'b010, 0, 8'h33); ex(3'b010, 0, 8'h0D);
    cmp("t1_wr");
    chk("t1_err", 32'(err), 32'h0);
    chk("t1_pdone_pulses", 32'(pd_cnt - pd0), 32'd1);

    // same packet, corrupted parity
    send(8'h0D, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
    send(8'hF2, 0);
    idle(2);
    ex(3'b010, 1, 8'h0D); ex(3'b010, 0, 8'h11); ex(3'b010, 0, 8'h22);
    ex(3'b010, 0, 8'h33); ex(3'b010, 0, 8'hF2);
    cmp("t2_wr");
    chk("t2_err", 32'(err), 32'h1);

    // addr 0 waits for FIFO0 to drain; header clears err
    fifo_empty = 3'b110;
    send(8'h08, 1);
    chk("t3_err_clr", 32'(err), 32'h0);
    data_in = 8'hAA; pkt_valid = 1'b1;
    repeat (4) begin
      #1 chk("t3_busy", 32'(busy), 32'h1);
      cyc();
      chk("t3_we_idle", 32'(write_enb), 32'h0);
    end
    chk("t3_nowr", 32'(got_q.size() - got_base), 32'd0);
    fifo_empty = 3'b111;
    send(8'hAA, 1); send(8'h55, 1); send(8'hF7, 0);
    idle(2);
    ex(3'b001, 1, 8'h08); ex(3'b001, 0, 8'hAA); ex(3'b001, 0, 8'h55); ex(3'b001, 0, 8'hF7);
    cmp("t3_wr");
    chk("t3_err", 32'(err), 32'h0);

    // FIFO2 full for two cycles mid-payload; other ports full must not stall
    send(8'h0E, 1); send(8'h01, 1);
    data_in = 8'h02; fifo_full = 3'b100;
    repeat (2) begin
      #1 chk("t4_busy", 32'(busy), 32'h1);
      cyc();
      chk("t4_we_stall", 32'(write_enb), 32'h0);
    end
    fifo_full = 3'b000;
    send(8'h02, 1);
    fifo_full = 3'b011;
    #1 chk("t4_other_full", 32'(busy), 32'h0);
    send(8'h03, 1);
    fifo_full = 3'b000;
    send(8'h0E, 0);
    idle(2);
    ex(3'b100, 1, 8'h0E); ex(3'b100, 0, 8'h01); ex(3'b100, 0, 8'h02);
    ex(3'b100, 0, 8'h03); ex(3'b100, 0, 8'h0E);
    cmp("t4_wr");
    chk("t4_err", 32'(err), 32'h0);

    // invalid address is dropped, then a normal packet to addr 0
    send(8'h0B, 1);
    #1 chk("t5_drop_busy", 32'(busy), 32'h0);
    send(8'h12, 1); send(8'h34, 1); send(8'h77, 0);
    idle(2);
    chk("t5_nowr", 32'(got_q.size() - got_base), 32'd0);
    send(8'h04, 1); send(8'h5A, 1); send(8'h5E, 0);
    idle(2);
    ex(3'b001, 1, 8'h04); ex(3'b001, 0, 8'h5A); ex(3'b001, 0, 8'h5E);
    cmp("t5_wr");
    chk("t5_err", 32'(err), 32'h0);

    // header says 4 payload bytes, only 2 sent
    send(8'h11, 1); send(8'hA1, 1); send(8'hB2, 1); send(8'h02, 0);
    idle(2);
    ex(3'b010, 1, 8'h11); ex(3'b010, 0, 8'hA1); ex(3'b010, 0, 8'hB2); ex(3'b010, 0, 8'h02);
    cmp("t6_wr");
    chk("t6_err", 32'(err), 32'h0);
    chk("t6_lenerr", 32'(len_err), 32'(LEN_EXP));

    // soft reset of FIFO1 mid-payload
    send(8'h0D, 1);
    chk("t6_lenerr_clr", 32'(len_err), 32'h0);
    send(8'h11, 1);
    data_in = 8'h22; pkt_valid = 1'b1; soft_reset = 3'b010;
    cyc();
    chk("t6_srst_we", 32'(write_enb), 32'h0);
    soft_reset = 3'b000;
    #1 chk("t6_drop_busy", 32'(busy), 32'h0);
    send(8'h33, 1); send(8'h0D, 0);
    idle(2);
    ex(3'b010, 1, 8'h0D); ex(3'b010, 0, 8'h11);
    cmp("t6_srst_wr");
    send(8'h04, 1); send(8'h5A, 1); send(8'h5E, 0);
    idle(2);
    ex(3'b001, 1, 8'h04); ex(3'b001, 0, 8'h5A); ex(3'b001, 0, 8'h5E);
    cmp("t6_after_srst");

    // reset mid-packet
    send(8'h0D, 1); send(8'h11, 1);
    data_in = 8'h22; reset = 1'b1;
    cyc();
    chk("t7_rst_we", 32'(write_enb), 32'h0);
    chk("t7_rst_dout", 32'(dout), 32'h00);
    chk("t7_rst_lfd", 32'(lfd_state), 32'h0);
    reset = 1'b0;
    idle(1);
    send(8'h04, 1); send(8'h5A, 1); send(8'h5E, 0);
    idle(2);
    ex(3'b010, 1, 8'h0D); ex(3'b010, 0, 8'h11);
    ex(3'b001, 1, 8'h04); ex(3'b001, 0, 8'h5A); ex(3'b001, 0, 8'h5E);
    cmp("t7_wr");
    chk("t7_err", 32'(err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/router_ingress.md
ROUTER_INGRESS -- requirements
Module: router_ingress

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: data_in in 8 packet byte; pkt_valid in 1 high for header+payload, low on parity byte.
REQ-004 SHALL have ports: fifo_full in 3, fifo_empty in 3, soft_reset in 3: per-output-FIFO status and abort.
REQ-005 SHALL have ports: dout out 8, write_enb out 3 (one-hot), lfd_state out 1: FIFO write bus, {lfd_state,dout} = FIFO word.
REQ-006 SHALL have ports: busy out 1 (upstream holds byte while high), parity_done out 1 (pulse), err out 1, len_err out 1.

Function
REQ-007 Header byte: [1:0] destination (0..2; 3 invalid), [7:2] payload length 1..63; packet = header, payload, parity (XOR of header and all payload bytes).
REQ-008 Byte accepted in a cycle iff state accepts and busy=0; busy is combinational from state, addr_reg, fifo_full.
REQ-009 dout, write_enb, lfd_state registered: accepted byte appears one cycle after acceptance; write_enb=0 when no byte accepted.
REQ-010 States: DECODE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, CHECK_PARITY, DROP.
REQ-011 DECODE (reset state): busy=0; on pkt_valid latch header into hdr_reg and addr_reg, clear parity accumulator and payload counter; addr=3 -> DROP; fifo_empty[addr]=1 -> LOAD_FIRST; else -> WAIT_EMPTY.
REQ-012 WAIT_EMPTY: busy=1; fifo_empty[addr_reg]=1 -> LOAD_FIRST.
REQ-013 LOAD_FIRST: busy=1; write hdr_reg with lfd_state=1, fold header into parity; -> LOAD_DATA.
REQ-014 LOAD_DATA: busy=fifo_full[addr_reg]; if not busy and pkt_valid=1, write payload byte (lfd_state=0), XOR into parity, payload counter +1 saturating at 63.
REQ-015 LOAD_DATA with busy=0 and pkt_valid=0: data_in is received parity; write it to FIFO, latch into rx_parity; -> CHECK_PARITY.
REQ-016 CHECK_PARITY: busy=1, one cycle; err<=(rx_parity!=computed parity); parity_done pulses 1 cycle; -> DECODE.
REQ-017 DROP: busy=0, no writes, bytes discarded; first cycle with pkt_valid=0 consumes parity -> DECODE.
REQ-018 soft_reset[addr_reg]=1 in WAIT_EMPTY, LOAD_FIRST, LOAD_DATA: no write that cycle; -> DROP if pkt_valid=1, else DECODE.
REQ-019 err, len_err hold until next header accepted in DECODE, then clear.
REQ-020 fifo_full on a non-selected FIFO SHALL NOT affect busy.

Reset
REQ-021 reset=1: state=DECODE, dout=8'h00, write_enb=3'b000, lfd_state=0, parity_done=0, err=0, len_err=0, all internal registers cleared.
REQ-022 reset mid-packet SHALL abandon packet; no further writes; next pkt_valid=1 byte treated as header.

Configuration
REQ-023 ROUTER_INGRESS_LEN_CHECK_EN defined: in CHECK_PARITY len_err<=(payload counter != hdr_reg[7:2]).
REQ-024 ROUTER_INGRESS_LEN_CHECK_EN undefined: payload counter absent, len_err tied 0.

Structure
REQ-025 Shared package router_pkg SHALL hold state enum, ADDR_INVALID=2'd3, header field positions, MAX_PAYLOAD=63, NUM_PORTS=3.
REQ-026 Parity accumulator SHALL be sub-module router_parity (clear, enable, byte in, 8-bit parity out).

Verification
REQ-027 Header 8'h0D (len 3, addr 1), payload 11,22,33, parity 8'h0D^11^22^33, FIFO1 empty -> write_enb=3'b010 five writes, first lfd_state=1, err=0, parity_done one pulse.
REQ-028 Same packet with parity byte flipped -> all five bytes written, err=1 after CHECK_PARITY, cleared by next header.
REQ-029 Header addr 0, fifo_empty[0]=0 for 4 cycles -> busy=1, no writes until empty, then header written with lfd_state=1.
REQ-030 fifo_full[2]=1 for 2 cycles mid-payload -> busy=1 those cycles, held byte written once, no byte lost or duplicated.
REQ-031 Header 8'h0B (addr 3) -> no write_enb ever, busy=0, next packet to addr 0 delivered correctly.
REQ-032 With ROUTER_INGRESS_LEN_CHECK_EN, header len 4 but 2 payload bytes -> len_err=1; soft_reset[1] mid-payload -> writes stop next cycle, DROP to parity, then DECODE.
